// File: rtl/tt_um_nasser_hadi_dff.sv
// tt_um_nasser_hadi_dff: 8-bit D/T/SET/CLR register with parity/zero/ones/change flags
// Ports: clk; rst_n (active-high sync reset); ena (design select); ui_in = D;
//        uio_in[1:0]=MODE, [2]=CE, [3]=INV; uo_out = Q or ~Q; uio_out[7:4] = {chg, ones, zero, parity};
//        uio_oe = 8'hF0
module tt_um_nasser_hadi_dff (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0] q_q, q_d, p_q;
  logic       chg_q;
  logic [1:0] mode;
  logic       ce, inv, unused_ok;
  assign mode = uio_in[1:0];
  assign ce   = uio_in[2];
  assign inv  = uio_in[3];
  always_comb q_d = mode == 2'b00 ? ui_in :
                    mode == 2'b01 ? q_q ^ ui_in :
                    mode == 2'b10 ? q_q | ui_in : q_q & ~ui_in;
  // rst_n is active-high despite its name
  always_ff @(posedge clk)
    if (rst_n) begin
      q_q   <= '0;
      p_q   <= '0;
      chg_q <= 1'b0;
    end else if (ena && ce) begin
      q_q   <= q_d;
      p_q   <= q_q;
      chg_q <= q_d != q_q;
    end
  assign uo_out    = inv ? ~q_q : q_q;
  assign uio_out   = {chg_q, &q_q, ~|q_q, ^q_q, 4'b0000};
  assign uio_oe    = 8'hF0;
  // P is kept as architectural state but has no output path
  assign unused_ok = &{1'b0, uio_in[7:4], p_q};
endmodule

// File: tb/tb_tt_um_nasser_hadi_dff.sv
// tb_tt_um_nasser_hadi_dff: randomized and directed self-checking bench against a behavioural model
module tb_tt_um_nasser_hadi_dff;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = '0, uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int         checks = 0, errors = 0;
  logic [7:0] mq = '0;
  logic       mchg = 1'b0;

  tt_um_nasser_hadi_dff dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] flags(input logic [7:0] q, input logic c);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += q[i];
    return {c, q == 8'hFF, q == 8'h00, ones % 2 == 1, 4'b0000};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".uo"}, uo_out, uio_in[3] ? ~mq : mq);
    chk({tag, ".flags"}, uio_out, flags(mq, mchg));
    chk({tag, ".oe"}, uio_oe, 8'hF0);
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic c, input logic v, input logic [7:0] d, input string tag);
    logic [7:0] nq;
    rst_n = r; ena = e; uio_in = {4'($urandom), v, c, m}; ui_in = d;
    @(posedge clk);
    if (r) begin
      mq = '0; mchg = 1'b0;
    end else if (e && c) begin
      case (m)
        2'd0: nq = d;
        2'd1: nq = mq ^ d;
        2'd2: nq = mq | d;
        default: nq = mq & ~d;
      endcase
      mchg = nq != mq;
      mq = nq;
    end
    #1 check_all(tag);
  endtask

  initial begin
    step(1, 0, 2'd2, 1, 0, 8'h77, "reset");
    chk("reset.uo", uo_out, 8'h00);
    chk("reset.flags", uio_out, 8'h20);
    uio_in[3] = 1'b1; #1 chk("reset.inv", uo_out, 8'hFF);
    step(0, 1, 2'd0, 1, 0, 8'hA5, "loadA5");
    chk("loadA5.uo", uo_out, 8'hA5);
    chk("loadA5.flags", uio_out, 8'h80);
    step(0, 1, 2'd1, 1, 0, 8'hFF, "tog1");
    chk("tog1.uo", uo_out, 8'h5A);
    step(0, 1, 2'd1, 1, 0, 8'hFF, "tog2");
    chk("tog2.uo", uo_out, 8'hA5);
    chk("tog2.chg", uio_out[7], 1'b1);
    step(0, 1, 2'd0, 1, 0, 8'h0F, "load0F");
    step(0, 1, 2'd2, 1, 0, 8'hF0, "set");
    chk("set.ones", uio_out[6], 1'b1);
    step(0, 1, 2'd3, 1, 0, 8'hFF, "clr");
    chk("clr.zero", uio_out[5], 1'b1);
    step(0, 1, 2'd0, 1, 0, 8'h3C, "load3C");
    for (int i = 0; i < 3; i++) step(0, 1, 2'd0, 0, 0, 8'h00, "ce0");
    for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 1, 0, 8'h00, "ena0");
    chk("hold.uo", uo_out, 8'h3C);
    step(0, 1, 2'd0, 1, 0, 8'h3C, "reload");
    chk("reload.chg", uio_out[7], 1'b0);
    uio_in[3] = 1'b1; #1;
    chk("inv.uo", uo_out, 8'hC3);
    chk("inv.flags", uio_out, flags(8'h3C, 1'b0));
    ui_in = 8'hFF; uio_in[1:0] = 2'd2; #1;
    chk("midcycle.uo", uo_out, 8'hC3);
    step(1, 1, 2'd0, 1, 0, 8'hFF, "rst_prio");
    chk("rst_prio.uo", uo_out, 8'h00);
    chk("rst_prio.flags", uio_out, 8'h20);
    step(0, 1, 2'd1, 1, 0, 8'h81, "post_rst");
    chk("post_rst.uo", uo_out, 8'h81);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 7) != 0, 2'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), "rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
